mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port memory between the multicycle core's instruction fetch and its load/store data path.
//  Accepts one request per requester with a req/gnt handshake and arbitrates round-robin.
//  Drives the memory port, then returns read data with a one-cycle rvalid pulse.
//  Sits between the control unit/datapath and the unified instruction/data memory.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width
//  MEM_LAT  1   cycles from the mem_en cycle to valid mem_rdata; must be >=1 (elaboration error if 0)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       reset, asynchronous, active-low
//  i_req      in   1       fetch request; hold with i_addr stable until i_gnt
//  i_addr     in   ADDR_W  fetch address
//  i_gnt      out  1       fetch accepted (combinational, IDLE only)
//  i_rvalid   out  1       one-cycle pulse: i_rdata valid
//  i_rdata    out  DATA_W  fetched instruction; registered, holds until next fetch response
//  d_req      in   1       data request; hold with d_we/d_addr/d_wdata stable until d_gnt
//  d_we       in   1       1 = store, 0 = load
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_gnt      out  1       data accepted (combinational, IDLE only)
//  d_rvalid   out  1       one-cycle pulse: load data valid / store complete
//  d_rdata    out  DATA_W  load data; registered; not updated by stores
//  mem_en     out  1       memory access strobe, exactly one cycle per transaction
//  mem_we     out  1       memory write enable; only ever 1 with mem_en on a data store
//  mem_addr   out  ADDR_W  latched address
//  mem_wdata  out  DATA_W  latched store data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en
//  busy       out  1       1 in any state except IDLE
// BEHAVIOUR
//  States:
//   IDLE -> ISSUE  on any req; latches winner, we, addr, wdata
//   ISSUE -> WAIT  unconditionally
//   WAIT -> RESP   when cnt == MEM_LAT-1
//   RESP -> IDLE   unconditionally
//  Winner selection:
//   - Single request wins.
//   - Both requesting: the side NOT in last_win wins; last_win updates on every grant.
//  Handshakes:
//   - Grant: gnt asserted combinationally in IDLE for the winner only; never both.
//   - A requester may drop req the cycle after gnt.
//   - Req dropped before gnt: nothing issued, no state change.
//   - Req asserted while busy: waits; arbitrated in the next IDLE cycle.
//  Memory port (ISSUE):
//   - mem_en=1; mem_we=latched we (forced 0 for fetch); mem_addr/mem_wdata from latches.
//   - In all other states mem_en=0 and mem_we=0; mem_addr/mem_wdata keep last latched values.
//  Data capture:
//   - WAIT counts MEM_LAT cycles; cnt width $clog2(MEM_LAT+1); cnt cleared on ISSUE.
//   - mem_rdata captured into the winner's rdata register at the clock edge that leaves WAIT.
//   - Fetch captures always; data captures only when we=0.
//  Response: RESP drives the winner's rvalid=1 for exactly one cycle.
//  Latency: gnt in cycle T -> mem_en in T+1 -> rvalid in T+2+MEM_LAT -> IDLE in T+3+MEM_LAT.
//   - MEM_LAT=1: gnt at 0, rvalid at 3, next gnt earliest at 4.
//  Reset (rst_n low, any time including mid-transaction):
//   - state=IDLE, cnt=0, last_win=DATA (fetch wins the first tie).
//   - All outputs 0, including rdata and latches.
//   - In-flight transaction is dropped with no rvalid; the requester must re-request.
// TESTING
//  - Lone fetch, MEM_LAT=1, i_addr=0x10, mem returns 0x00500093 -> i_gnt cycle 0, mem_en/addr=0x10 cycle 1, i_rvalid+i_rdata=0x00500093 cycle 3, busy cycles 1-3.
//  - Store d_addr=0x40, d_wdata=0xDEADBEEF -> mem_en=mem_we=1 for one cycle with addr 0x40, data 0xDEADBEEF; d_rvalid pulse; d_rdata unchanged.
//  - i_req and d_req held high together from reset -> grants alternate I,D,I,D; never both gnt; each rvalid to the correct side.
//  - MEM_LAT=3, load 0x80 with mem_rdata=0x12345678 valid 3 cycles after mem_en -> d_rvalid exactly 5 cycles after d_gnt, d_rdata=0x12345678.
//  - rst_n low during WAIT -> all outputs 0 immediately (asynchronous); no rvalid after release; a fresh req is granted normally.
//  - d_req pulsed high and dropped while busy with a fetch -> no data transaction issued; mem_we never asserted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and load/store traffic, with a one-cycle rvalid pulse back to the winner.
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    generate
        if (MEM_LAT < 1) begin : g_lat_check
            $error("mem_port_arbiter: MEM_LAT must be >= 1");
        end
    endgenerate

    localparam int              CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic               last_win_d;
    logic               win_d;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  i_rdata_q;
    logic [DATA_W-1:0]  d_rdata_q;

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // On a tie the side that did not win last time is granted.
    always_comb begin
        next_state = state;
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        i_rvalid   = 1'b0;
        d_rvalid   = 1'b0;
        busy       = 1'b1;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (i_req && (!d_req || last_win_d)) begin
                    i_gnt = 1'b1;
                end else if (d_req) begin
                    d_gnt = 1'b1;
                end
                if (i_req || d_req) begin
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_en     = 1'b1;
                mem_we     = we_q;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == CNT_LAST) begin
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                i_rvalid   = !win_d;
                d_rvalid   = win_d;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Store data is only latched for a data win; fetches force we low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win_d <= 1'b1;
            win_d      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (i_gnt || d_gnt) begin
            last_win_d <= d_gnt;
            win_d      <= d_gnt;
            we_q       <= d_gnt && d_we;
            addr_q     <= d_gnt ? d_addr : i_addr;
            if (d_gnt) begin
                wdata_q <= d_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (state == S_ISSUE) begin
                cnt <= '0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
            // The last WAIT cycle is the one where mem_rdata is valid.
            if (state == S_WAIT && cnt == CNT_LAST) begin
                if (!win_d) begin
                    i_rdata_q <= mem_rdata;
                end else if (!we_q) begin
                    d_rdata_q <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, corner-case
// sequences, and randomized traffic against a transaction-level model.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        i_req_3, d_req_3, d_we_3;
    logic [31:0] i_addr_3, d_addr_3, d_wdata_3;
    logic        i_gnt_3, i_rvalid_3, d_gnt_3, d_rvalid_3, mem_en_3, mem_we_3, busy_3;
    logic [31:0] i_rdata_3, d_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;

    int n_checks;
    int n_bad;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req_3), .i_addr(i_addr_3), .i_gnt(i_gnt_3), .i_rvalid(i_rvalid_3), .i_rdata(i_rdata_3),
        .d_req(d_req_3), .d_we(d_we_3), .d_addr(d_addr_3), .d_wdata(d_wdata_3),
        .d_gnt(d_gnt_3), .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
        .mem_rdata(mem_rdata_3), .busy(busy_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of a never-written memory word.
    function automatic logic [31:0] init_val(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        if (a == 32'h80) return 32'h1234_5678;
        return (a * 32'h0101_0101) ^ 32'hC0DE_0000;
    endfunction

    // One-cycle-latency RAM; returns a poison value when not addressed.
    logic [31:0] ram      [0:255];
    bit          wr_valid [0:255];
    logic [31:0] rd_pipe;
    assign mem_rdata = rd_pipe;

    always @(posedge clk) begin
        if (mem_en) begin
            rd_pipe <= wr_valid[mem_addr[9:2]] ? ram[mem_addr[9:2]] : init_val(mem_addr);
            if (mem_we) begin
                ram[mem_addr[9:2]]      <= mem_wdata;
                wr_valid[mem_addr[9:2]] <= 1'b1;
            end
        end else begin
            rd_pipe <= 32'hBAD0_0001;
        end
    end

    logic [31:0] p3 [0:2];
    assign mem_rdata_3 = p3[2];
    always @(posedge clk) begin
        p3[0] <= mem_en_3 ? init_val(mem_addr_3) : 32'hBAD0_0003;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_ig;
        logic        e_dg;
        logic        e_en;
        logic        e_we;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_irv;
        logic [31:0] e_ird;
        logic        e_drv;
        logic [31:0] e_drd;
        logic        e_busy;
    } vec_t;

    vec_t vecs [9];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        i_req   = v.i_req;
        i_addr  = v.i_addr;
        d_req   = v.d_req;
        d_we    = v.d_we;
        d_addr  = v.d_addr;
        d_wdata = v.d_wdata;
    endtask

    task automatic clear_inputs();
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        i_req_3 = 1'b0; i_addr_3 = '0; d_req_3 = 1'b0; d_we_3 = 1'b0; d_addr_3 = '0; d_wdata_3 = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        @(negedge clk);
        while (busy && c < 20) begin
            @(negedge clk);
            c++;
        end
        check_bit("idle timeout", busy, 1'b0);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_g, last_g, lat, n_en, n_we, n_dg;
        bit want_d, pend_side, found;
        // model state for the randomized phase
        int cyc, g_cyc;
        bit i_pend, d_pend, lw_d, g_d, g_we, idle, e_ig, e_dg, e_en, e_we, e_rv;
        logic [31:0] g_addr, g_wdata, e_maddr, e_mwd, e_ird, e_drd, rd_val;
        logic [7:0]  idx;
        logic [31:0] sh   [0:255];
        bit          sh_v [0:255];

        n_checks = 0;
        n_bad    = 0;

        vecs[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0, 1'b1};
        vecs[2] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0, 1'b1};
        vecs[3] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        1'b1, 32'h0050_0093, 1'b0, 32'h0, 1'b1};
        vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 32'h0050_0093, 1'b0, 32'h0, 1'b0};
        vecs[5] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0050_0093, 1'b0, 32'h0, 1'b1};
        vecs[6] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0050_0093, 1'b0, 32'h0, 1'b1};
        vecs[7] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0050_0093, 1'b1, 32'h0, 1'b1};
        vecs[8] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0050_0093, 1'b0, 32'h0, 1'b0};

        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("reset busy", busy, 1'b0);
        check_bit("reset i_gnt", i_gnt, 1'b0);
        check_bit("reset d_gnt", d_gnt, 1'b0);
        check_bit("reset mem_en", mem_en, 1'b0);
        check_bit("reset mem_we", mem_we, 1'b0);
        check_output("reset mem_addr", mem_addr, 32'h0);
        check_output("reset mem_wdata", mem_wdata, 32'h0);
        check_bit("reset i_rvalid", i_rvalid, 1'b0);
        check_bit("reset d_rvalid", d_rvalid, 1'b0);
        check_output("reset i_rdata", i_rdata, 32'h0);
        check_output("reset d_rdata", d_rdata, 32'h0);
        check_bit("reset busy_3", busy_3, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Lone fetch followed by a lone store.
        for (int k = 0; k < 9; k++) begin
            apply_stimulus(vecs[k]);
            @(negedge clk);
            check_bit($sformatf("row%0d i_gnt", k), i_gnt, vecs[k].e_ig);
            check_bit($sformatf("row%0d d_gnt", k), d_gnt, vecs[k].e_dg);
            check_bit($sformatf("row%0d mem_en", k), mem_en, vecs[k].e_en);
            check_bit($sformatf("row%0d mem_we", k), mem_we, vecs[k].e_we);
            check_output($sformatf("row%0d mem_addr", k), mem_addr, vecs[k].e_maddr);
            check_output($sformatf("row%0d mem_wdata", k), mem_wdata, vecs[k].e_mwdata);
            check_bit($sformatf("row%0d i_rvalid", k), i_rvalid, vecs[k].e_irv);
            check_output($sformatf("row%0d i_rdata", k), i_rdata, vecs[k].e_ird);
            check_bit($sformatf("row%0d d_rvalid", k), d_rvalid, vecs[k].e_drv);
            check_output($sformatf("row%0d d_rdata", k), d_rdata, vecs[k].e_drd);
            check_bit($sformatf("row%0d busy", k), busy, vecs[k].e_busy);
            next_cycle();
        end

        // Both requesters held high: grants alternate I,D,I,D every 4 cycles.
        do_reset();
        i_req = 1'b1; i_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        n_g = 0; last_g = -1; want_d = 1'b0; pend_side = 1'b0;
        for (int c = 0; c < 40 && n_g < 4; c++) begin
            @(negedge clk);
            check_bit("alt double gnt", i_gnt & d_gnt, 1'b0);
            check_bit("alt double rvalid", i_rvalid & d_rvalid, 1'b0);
            if (i_rvalid || d_rvalid) begin
                check_bit("alt rvalid side", d_rvalid, pend_side);
                if (i_rvalid) check_output("alt i_rdata", i_rdata, init_val(32'h20));
                if (d_rvalid) check_output("alt d_rdata", d_rdata, init_val(32'h30));
            end
            if (i_gnt || d_gnt) begin
                check_bit("alt grant side", d_gnt, want_d);
                if (last_g >= 0) check_output("alt grant spacing", 32'(c - last_g), 32'd4);
                last_g    = c;
                want_d    = !want_d;
                pend_side = d_gnt;
                n_g++;
            end
            next_cycle();
        end
        check_output("alt grant count", 32'(n_g), 32'd4);
        i_req = 1'b0; d_req = 1'b0;
        wait_idle();

        // Asynchronous reset during WAIT drops the fetch.
        i_req = 1'b1; i_addr = 32'h50;
        @(negedge clk);
        check_bit("rstwait i_gnt", i_gnt, 1'b1);
        next_cycle();
        i_req = 1'b0;
        next_cycle();
        #2 rst_n = 1'b0;
        #1;
        check_bit("rstwait busy", busy, 1'b0);
        check_bit("rstwait mem_en", mem_en, 1'b0);
        check_output("rstwait mem_addr", mem_addr, 32'h0);
        check_output("rstwait i_rdata", i_rdata, 32'h0);
        check_output("rstwait d_rdata", d_rdata, 32'h0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_bit("rstwait no rvalid", i_rvalid, 1'b0);
            next_cycle();
        end
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
        @(negedge clk);
        check_bit("rstwait fresh d_gnt", d_gnt, 1'b1);
        next_cycle();
        d_req = 1'b0;
        lat = 1; found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (d_rvalid) begin found = 1'b1; break; end
            lat++;
            next_cycle();
        end
        check_bit("rstwait fresh rvalid seen", found, 1'b1);
        check_output("rstwait fresh latency", 32'(lat), 32'd3);
        check_output("rstwait fresh d_rdata", d_rdata, init_val(32'h60));
        next_cycle();
        wait_idle();

        // A store request pulsed and dropped while busy must never issue.
        n_en = 0; n_we = 0; n_dg = 0;
        i_req = 1'b1; i_addr = 32'h70;
        @(negedge clk);
        check_bit("pulse i_gnt", i_gnt, 1'b1);
        next_cycle();
        i_req = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            d_req = (c == 1); d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h0BAD_F00D;
            @(negedge clk);
            if (mem_en) n_en++;
            if (mem_we) n_we++;
            if (d_gnt)  n_dg++;
            if (i_rvalid) check_output("pulse i_rdata", i_rdata, init_val(32'h70));
            next_cycle();
        end
        check_output("pulse mem_en count", 32'(n_en), 32'd1);
        check_output("pulse mem_we count", 32'(n_we), 32'd0);
        check_output("pulse d_gnt count", 32'(n_dg), 32'd0);
        d_req = 1'b0; d_we = 1'b0;

        // MEM_LAT=3 load: rvalid five cycles after grant.
        d_req_3 = 1'b1; d_we_3 = 1'b0; d_addr_3 = 32'h80;
        @(negedge clk);
        check_bit("lat3 d_gnt", d_gnt_3, 1'b1);
        next_cycle();
        d_req_3 = 1'b0;
        lat = 1; found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (d_rvalid_3) begin found = 1'b1; break; end
            lat++;
            next_cycle();
        end
        check_bit("lat3 rvalid seen", found, 1'b1);
        check_output("lat3 latency", 32'(lat), 32'd5);
        check_output("lat3 d_rdata", d_rdata_3, 32'h1234_5678);
        next_cycle();
        @(negedge clk);
        check_bit("lat3 rvalid pulse width", d_rvalid_3, 1'b0);
        next_cycle();

        // Randomized traffic against a transaction-timing model.
        do_reset();
        for (int k = 0; k < 256; k++) begin sh[k] = '0; sh_v[k] = 1'b0; end
        sh[8'h10] = 32'hDEADBEEF; sh_v[8'h10] = 1'b1;
        g_cyc = -100; lw_d = 1'b1; g_d = 1'b0; g_we = 1'b0;
        g_addr = '0; g_wdata = '0; e_maddr = '0; e_mwd = '0; e_ird = '0; e_drd = '0; rd_val = '0;
        i_pend = 1'b0; d_pend = 1'b0;
        for (cyc = 0; cyc < 400; cyc++) begin
            if (!i_pend && $urandom_range(2) == 0) begin
                i_pend = 1'b1;
                idx    = 8'($urandom_range(255));
                i_addr = {22'b0, idx, 2'b00};
            end
            if (d_pend && $urandom_range(7) == 0) begin
                d_pend = 1'b0;
            end else if (!d_pend && $urandom_range(2) == 0) begin
                d_pend  = 1'b1;
                d_we    = 1'($urandom_range(1));
                idx     = 8'($urandom_range(255));
                d_addr  = {22'b0, idx, 2'b00};
                d_wdata = $urandom;
            end
            i_req = i_pend;
            d_req = d_pend;

            idle = (cyc >= g_cyc + 4);
            e_ig = idle && i_pend && (!d_pend || lw_d);
            e_dg = idle && d_pend && !e_ig;
            e_en = (cyc == g_cyc + 1);
            e_we = e_en && g_d && g_we;
            e_rv = (cyc == g_cyc + 3);
            if (e_en) begin
                idx    = g_addr[9:2];
                rd_val = sh_v[idx] ? sh[idx] : init_val(g_addr);
                if (e_we) begin sh[idx] = g_wdata; sh_v[idx] = 1'b1; end
            end
            if (e_rv) begin
                if (!g_d) e_ird = rd_val;
                else if (!g_we) e_drd = rd_val;
            end

            @(negedge clk);
            check_bit("rnd i_gnt", i_gnt, e_ig);
            check_bit("rnd d_gnt", d_gnt, e_dg);
            check_bit("rnd mem_en", mem_en, e_en);
            check_bit("rnd mem_we", mem_we, e_we);
            check_output("rnd mem_addr", mem_addr, e_maddr);
            if (e_we) check_output("rnd mem_wdata", mem_wdata, e_mwd);
            check_bit("rnd i_rvalid", i_rvalid, e_rv && !g_d);
            check_bit("rnd d_rvalid", d_rvalid, e_rv && g_d);
            check_output("rnd i_rdata", i_rdata, e_ird);
            check_output("rnd d_rdata", d_rdata, e_drd);
            check_bit("rnd busy", busy, !idle);

            if (e_ig || e_dg) begin
                g_cyc  = cyc;
                g_d    = e_dg;
                g_we   = e_dg && d_we;
                g_addr = e_dg ? d_addr : i_addr;
                if (e_dg) begin g_wdata = d_wdata; e_mwd = d_wdata; end
                e_maddr = g_addr;
                lw_d    = e_dg;
                if (e_ig) i_pend = 1'b0;
                else      d_pend = 1'b0;
            end
            next_cycle();
        end
        clear_inputs();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
